// File: rtl/vend_dispenser.sv
// Actuator sequencer behind the vending FSM: queues {out,change} events and plays them out as
// motor / coin-ejector pulses. Define VEND_TALLY_EN to add saturating sold/coin tally outputs.
module vend_dispenser #(
  parameter int FIFO_DEPTH = 4,
  parameter int MOTOR_CYC  = 8,
  parameter int COIN_CYC   = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        out,
  input  logic [1:0]  change,
  output logic        motor,
  output logic        eject10,
  output logic        eject5,
  output logic        busy,
  output logic        overflow
`ifdef VEND_TALLY_EN
  ,
  output logic [15:0] sold_cnt,
  output logic [15:0] coins5_cnt,
  output logic [15:0] coins10_cnt
`endif
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int MAX_A = (MOTOR_CYC > COIN_CYC) ? MOTOR_CYC : COIN_CYC;
  localparam int MAXC  = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CW    = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {IDLE, MOTOR, GAP_M, COIN10, GAP_10, COIN5, GAP_5} state_t;

  state_t         state, stateNext;
  logic [CW-1:0]  phase;
  logic [2:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [PW:0]    count;
  logic [1:0]     curChange;
  logic [2:0]     head;
  logic           push, pop, doPush, full, empty, enter, phaseDone;

  assign head      = mem[rdPtr];
  assign push      = out | (|change);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign doPush    = push && (!full || pop);
  assign enter     = (stateNext != state);
  assign phaseDone = (phase == '0);
  assign busy      = (state != IDLE) || !empty;

  // Each phase lasts its load value + 1 cycles, counting down to zero.
  function automatic logic [CW-1:0] phaseLoad(input state_t s);
    case (s)
      MOTOR:                 return CW'(MOTOR_CYC - 1);
      COIN10, COIN5:         return CW'(COIN_CYC - 1);
      GAP_M, GAP_10, GAP_5:  return CW'(GAP_CYC - 1);
      default:               return '0;
    endcase
  endfunction

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head[2])      stateNext = MOTOR;
          else if (head[1]) stateNext = COIN10;
          else              stateNext = COIN5;
        end
      end
      MOTOR:  if (phaseDone) stateNext = GAP_M;
      GAP_M: begin
        if (phaseDone) begin
          if (curChange[1])      stateNext = COIN10;
          else if (curChange[0]) stateNext = COIN5;
          else                   stateNext = IDLE;
        end
      end
      COIN10: if (phaseDone) stateNext = GAP_10;
      GAP_10: if (phaseDone) stateNext = curChange[0] ? COIN5 : IDLE;
      COIN5:  if (phaseDone) stateNext = GAP_5;
      GAP_5:  if (phaseDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Actuator drives are registered off the next state so they rise on the pop edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      curChange <= 2'b00;
      motor     <= 1'b0;
      eject10   <= 1'b0;
      eject5    <= 1'b0;
    end else begin
      state <= stateNext;
      if (enter)           phase <= phaseLoad(stateNext);
      else if (!phaseDone) phase <= phase - CW'(1);
      if (pop)             curChange <= head[1:0];
      motor   <= (stateNext == MOTOR);
      eject10 <= (stateNext == COIN10);
      eject5  <= (stateNext == COIN5);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      case ({doPush, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= {out, change};
  end

`ifdef VEND_TALLY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sold_cnt    <= '0;
      coins5_cnt  <= '0;
      coins10_cnt <= '0;
    end else if (enter) begin
      if (stateNext == MOTOR  && sold_cnt    != 16'hFFFF) sold_cnt    <= sold_cnt + 16'd1;
      if (stateNext == COIN5  && coins5_cnt  != 16'hFFFF) coins5_cnt  <= coins5_cnt + 16'd1;
      if (stateNext == COIN10 && coins10_cnt != 16'hFFFF) coins10_cnt <= coins10_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Testbench for vend_dispenser: directed and random event streams against a queue-based model
// that expands each event into its per-cycle actuator pattern.
module tb_vend_dispenser;

  localparam int FIFO_DEPTH = 4;
  localparam int MOTOR_CYC  = 8;
  localparam int COIN_CYC   = 4;
  localparam int GAP_CYC    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       out;
  logic [1:0] change;
  logic       motor, eject10, eject5, busy, overflow;

  int assertCount = 0;
  int failCount   = 0;
  int motorPulses = 0;
  logic prevMotor = 1'b0;

  logic [2:0] mFifo[$];
  logic [2:0] mSeq[$];
  logic       mOverflow = 1'b0;

  vend_dispenser #(
    .FIFO_DEPTH(FIFO_DEPTH), .MOTOR_CYC(MOTOR_CYC), .COIN_CYC(COIN_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .out(out), .change(change),
    .motor(motor), .eject10(eject10), .eject5(eject5), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // An event becomes a flat list of per-cycle {motor,eject10,eject5} values, gaps included.
  task automatic expand(input logic [2:0] ev);
    if (ev[2]) begin
      repeat (MOTOR_CYC) mSeq.push_back(3'b100);
      repeat (GAP_CYC)   mSeq.push_back(3'b000);
    end
    if (ev[1]) begin
      repeat (COIN_CYC) mSeq.push_back(3'b010);
      repeat (GAP_CYC)  mSeq.push_back(3'b000);
    end
    if (ev[0]) begin
      repeat (COIN_CYC) mSeq.push_back(3'b001);
      repeat (GAP_CYC)  mSeq.push_back(3'b000);
    end
  endtask

  task automatic modelEdge(input logic o, input logic [1:0] c);
    bit wasIdle;
    bit wasFull;
    bit popNow;
    logic [2:0] ev;
    wasIdle = (mSeq.size() == 0);
    wasFull = (mFifo.size() == FIFO_DEPTH);
    if (!wasIdle) void'(mSeq.pop_front());
    popNow = wasIdle && (mFifo.size() > 0);
    if (popNow) begin
      ev = mFifo.pop_front();
      expand(ev);
    end
    if (o || c != 2'b00) begin
      if (!wasFull || popNow) mFifo.push_back({o, c});
      else                    mOverflow = 1'b1;
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    mSeq.delete();
    mOverflow = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] expAct;
    logic       expBusy;
    expAct  = (mSeq.size() != 0) ? mSeq[0] : 3'b000;
    expBusy = (mSeq.size() != 0) || (mFifo.size() != 0);
    assertCount++;
    assert ({motor, eject10, eject5} === expAct) else begin
      failCount++;
      $error("[TB] FAIL %s actuators: observed %b expected %b at %0t", tag, {motor, eject10, eject5}, expAct, $time);
    end
    assertCount++;
    assert (busy === expBusy) else begin
      failCount++;
      $error("[TB] FAIL %s busy: observed %b expected %b at %0t", tag, busy, expBusy, $time);
    end
    assertCount++;
    assert (overflow === mOverflow) else begin
      failCount++;
      $error("[TB] FAIL %s overflow: observed %b expected %b at %0t", tag, overflow, mOverflow, $time);
    end
  endtask

  // Drive inputs mid-cycle, let the edge happen, then check 1 time unit later.
  task automatic applyStimulus(input logic o, input logic [1:0] c, input string tag);
    out    = o;
    change = c;
    @(posedge clk);
    modelEdge(o, c);
    #1;
    if (motor && !prevMotor) motorPulses++;
    prevMotor = motor;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, tag);
  endtask

  task automatic doReset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    modelReset();
    prevMotor = 1'b0;
    checkOutput(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    reset  = 1'b0;
    out    = 1'b1;
    change = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held");
    out    = 1'b0;
    change = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    idleCycles(4, "post_reset_idle");

    $display("[TB] motor only");
    applyStimulus(1'b1, 2'b00, "motor_only");
    idleCycles(14, "motor_only");

    $display("[TB] motor plus 5 change");
    applyStimulus(1'b1, 2'b01, "motor_c5");
    idleCycles(22, "motor_c5");

    $display("[TB] change 15 only");
    applyStimulus(1'b0, 2'b11, "c15");
    idleCycles(18, "c15");

    $display("[TB] overflow with held out");
    motorPulses = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, "hold_out");
    idleCycles(60, "hold_drain");
    assertCount++;
    assert (motorPulses === 5) else begin
      failCount++;
      $error("[TB] FAIL hold_pulses: observed %0d expected %0d", motorPulses, 5);
    end

    $display("[TB] reset mid motor");
    applyStimulus(1'b1, 2'b11, "mid_reset");
    applyStimulus(1'b1, 2'b00, "mid_reset");
    idleCycles(3, "mid_reset");
    doReset("mid_reset_async");
    idleCycles(20, "after_mid_reset");

    $display("[TB] random dense");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand_dense");
      else        applyStimulus(1'b0, 2'b00, "rand_dense");
    end
    doReset("rand_reset");

    $display("[TB] random sparse");
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand_sparse");
      else       applyStimulus(1'b0, 2'b00, "rand_sparse");
    end
    idleCycles(80, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
